nibble_sub16: RTL and testbench
===============================

NIBBLE_SUB16 -- requirements
Module: nibble_sub16

Interface
REQ-001 SHALL provide parameter: WIDTH, 16, operand width in bits; legal values are multiples of 4 only.
REQ-002 SHALL provide port: clk  in  1  single clock, all state updates on rising edge.
REQ-003 SHALL provide port: rst_n  in  1  reset, synchronous, active-low.
REQ-004 SHALL provide port: in_valid  in  1  operand set offered.
REQ-005 SHALL provide port: in_ready  out  1  block accepts operands.
REQ-006 SHALL provide ports: a, b  in  WIDTH each  minuend and subtrahend, both unsigned or two's complement.
REQ-007 SHALL provide port: bin  in  1  borrow-in.
REQ-008 SHALL provide port: out_valid  out  1  result available.
REQ-009 SHALL provide port: out_ready  in  1  consumer takes result.
REQ-010 SHALL provide ports: d  out  WIDTH  difference a-b-bin; bout  out  1  borrow-out; ovf  out  1  signed overflow.

Function
REQ-011 SHALL implement states IDLE, RUN, DONE: IDLE->RUN on in_valid&&in_ready; RUN->DONE after the final nibble; DONE->IDLE on out_ready.
REQ-012 SHALL drive in_ready=1 only in IDLE; a, b, bin SHALL be captured on the acceptance edge, and inputs SHALL be ignored in other states.
REQ-013 SHALL process one 4-bit nibble per RUN cycle, LSB nibble first: nib_d = a_nib + ~b_nib + c, with initial c = ~bin and c chained between nibbles in a register.
REQ-014 SHALL take WIDTH/4 RUN cycles; for WIDTH=16, out_valid SHALL rise 4 clock edges after the acceptance edge.
REQ-015 SHALL set bout = ~(final carry), i.e. 1 when a < b+bin unsigned.
REQ-016 SHALL set ovf = (a[MSB]^b[MSB]) & (a[MSB]^d_raw[MSB]), where d_raw is the unsaturated difference.
REQ-017 SHALL hold d, bout, ovf, out_valid stable while out_valid=1 && out_ready=0.
REQ-018 SHALL clear out_valid on the edge where out_valid&&out_ready, with in_ready=1 from the next cycle; no overlap of accept and deliver.
REQ-019 SHALL produce d=0 when a=b and bin=0, with bout=0 and ovf=0.
REQ-020 SHALL compute wrap-around modulo 2^WIDTH, e.g. 0x0000-0x0001 -> 0xFFFF, bout=1.

Reset
REQ-021 SHALL, with rst_n=0 at a rising edge, enter IDLE and clear d, bout, ovf, out_valid, the carry register, and the nibble index to 0.
REQ-022 SHALL, on reset mid-RUN or in DONE, abandon the transaction without emitting a result.
REQ-023 SHALL drive in_ready=0 during the reset cycle and 1 on the first cycle after rst_n returns high.

Configuration
REQ-024 SHALL, with macro NIBBLE_SUB_SAT_EN defined, force d=0 whenever bout=1 (unsigned saturating subtract); bout and ovf SHALL be reported unchanged.
REQ-025 SHALL, without NIBBLE_SUB_SAT_EN, output the wrapped difference per REQ-020, with no extra logic or latency.

Structure
REQ-026 SHALL place the state enum typedef, NIB_W=4 and NUM_NIB=WIDTH/NIB_W in a shared package nibble_sub_pkg.
REQ-027 SHALL implement the per-nibble arithmetic in one combinational sub-module, sub_nibble4: 4-bit carry-lookahead with inputs a4, b4 inverted internally and cin; outputs d4 and cout.
REQ-028 SHALL instantiate sub_nibble4 once and reuse it each RUN cycle through nibble-index muxing.

Verification
REQ-029 SHALL cover: a=0x24D7, b=0x03F8, bin=0 -> d=0x20DF, bout=0, ovf=0, out_valid 4 edges after accept.
REQ-030 SHALL cover: a=0x0000, b=0x0001, bin=0 -> d=0xFFFF, bout=1, ovf=0; with NIBBLE_SUB_SAT_EN -> d=0x0000, bout=1.
REQ-031 SHALL cover: a=0x8000, b=0x0001 -> d=0x7FFF, bout=0, ovf=1; and a=0x0005, b=0x0003, bin=1 -> d=0x0001, bout=0.
REQ-032 SHALL cover: out_ready held low 3 cycles after out_valid -> d/bout/ovf stable, in_ready=0, and a second in_valid is ignored until delivery.
REQ-033 SHALL cover: rst_n low for 1 cycle during the 2nd RUN cycle -> no out_valid, all outputs 0, and a new accept succeeds the next cycle.

Source files
------------

// File: rtl/nibble_sub_pkg.sv
// Shared types and sizing for the nibble-serial subtractor.
package nibble_sub_pkg;

   localparam int NIB_W     = 4;
   localparam int DEF_WIDTH = 16;
   localparam int NUM_NIB   = DEF_WIDTH / NIB_W;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_e;

   function automatic int calc_num_nib(input int width);
      return width / NIB_W;
   endfunction

   // Signed overflow of a - b: operand signs differ and the result sign departs from a.
   function automatic logic ovf_calc(input logic a_msb, input logic b_msb, input logic d_msb);
      return (a_msb ^ b_msb) & (a_msb ^ d_msb);
   endfunction

endpackage

// File: rtl/sub_nibble4.sv
// 4-bit carry-lookahead subtract slice: d4 = a4 + ~b4 + cin.
module sub_nibble4
   import nibble_sub_pkg::*;
(
   input  logic [NIB_W-1:0] a4,
   input  logic [NIB_W-1:0] b4,
   input  logic             cin,
   output logic [NIB_W-1:0] d4,
   output logic             cout
);

   logic [NIB_W-1:0] bn_s;
   logic [NIB_W-1:0] g_s;
   logic [NIB_W-1:0] p_s;
   logic [NIB_W:0]   c_s;

   // Generate/propagate terms and flat lookahead carries.
   always_comb begin
      bn_s   = ~b4;
      g_s    = a4 & bn_s;
      p_s    = a4 ^ bn_s;
      c_s[0] = cin;
      c_s[1] = g_s[0] | (p_s[0] & cin);
      c_s[2] = g_s[1] | (p_s[1] & g_s[0]) | (p_s[1] & p_s[0] & cin);
      c_s[3] = g_s[2] | (p_s[2] & g_s[1]) | (p_s[2] & p_s[1] & g_s[0])
             | (p_s[2] & p_s[1] & p_s[0] & cin);
      c_s[4] = g_s[3] | (p_s[3] & g_s[2]) | (p_s[3] & p_s[2] & g_s[1])
             | (p_s[3] & p_s[2] & p_s[1] & g_s[0])
             | (p_s[3] & p_s[2] & p_s[1] & p_s[0] & cin);
      d4     = p_s ^ c_s[NIB_W-1:0];
      cout   = c_s[NIB_W];
   end

endmodule

// File: rtl/nibble_sub16.sv
// Nibble-serial subtractor a - b - bin with valid/ready handshakes on both sides.
// Define NIBBLE_SUB_SAT_EN for an unsigned saturating result (d forced to 0 on borrow).
module nibble_sub16
   import nibble_sub_pkg::*;
#(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             bin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] d,
   output logic             bout,
   output logic             ovf
);

   localparam int NIBS  = calc_num_nib(WIDTH);
   localparam int IDX_W = (NIBS > 1) ? $clog2(NIBS) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBS - 1);

   state_e           state_q, state_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic [WIDTH-1:0] res_q, res_d;
   logic             carry_q, carry_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic [WIDTH-1:0] d_q, d_d;
   logic             bout_q, bout_d;
   logic             ovf_q, ovf_d;
   logic             out_valid_q, out_valid_d;

   logic [NIB_W-1:0] a_nib_s;
   logic [NIB_W-1:0] b_nib_s;
   logic [NIB_W-1:0] d4_s;
   logic             cout_s;
   logic [WIDTH-1:0] d_raw_s;

   assign a_nib_s = a_q[idx_q*NIB_W +: NIB_W];
   assign b_nib_s = b_q[idx_q*NIB_W +: NIB_W];

   sub_nibble4 u_sub_nibble4 (
      .a4   (a_nib_s),
      .b4   (b_nib_s),
      .cin  (carry_q),
      .d4   (d4_s),
      .cout (cout_s)
   );

   // Next-state, operand capture and per-nibble accumulation.
   always_comb begin
      state_d     = state_q;
      a_d         = a_q;
      b_d         = b_q;
      res_d       = res_q;
      carry_d     = carry_q;
      idx_d       = idx_q;
      d_d         = d_q;
      bout_d      = bout_q;
      ovf_d       = ovf_q;
      out_valid_d = out_valid_q;
      d_raw_s     = res_q;
      d_raw_s[idx_q*NIB_W +: NIB_W] = d4_s;

      case (state_q)
         IDLE: begin
            if (in_valid) begin
               a_d     = a;
               b_d     = b;
               carry_d = ~bin;
               idx_d   = {IDX_W{1'b0}};
               res_d   = {WIDTH{1'b0}};
               state_d = RUN;
            end else begin
               state_d = IDLE;
            end
         end
         RUN: begin
            res_d   = d_raw_s;
            carry_d = cout_s;
            if (idx_q == LAST_IDX) begin
               idx_d       = {IDX_W{1'b0}};
               bout_d      = ~cout_s;
               ovf_d       = ovf_calc(a_q[WIDTH-1], b_q[WIDTH-1], d_raw_s[WIDTH-1]);
`ifdef NIBBLE_SUB_SAT_EN
               d_d         = cout_s ? d_raw_s : {WIDTH{1'b0}};
`else
               d_d         = d_raw_s;
`endif
               out_valid_d = 1'b1;
               state_d     = DONE;
            end else begin
               idx_d = idx_q + IDX_W'(1'b1);
            end
         end
         DONE: begin
            if (out_ready) begin
               out_valid_d = 1'b0;
               state_d     = IDLE;
            end else begin
               out_valid_d = 1'b1;
            end
         end
         default: begin
            out_valid_d = 1'b0;
            state_d     = IDLE;
         end
      endcase
   end

   // State and datapath registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         a_q         <= {WIDTH{1'b0}};
         b_q         <= {WIDTH{1'b0}};
         res_q       <= {WIDTH{1'b0}};
         carry_q     <= 1'b0;
         idx_q       <= {IDX_W{1'b0}};
         d_q         <= {WIDTH{1'b0}};
         bout_q      <= 1'b0;
         ovf_q       <= 1'b0;
         out_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         a_q         <= a_d;
         b_q         <= b_d;
         res_q       <= res_d;
         carry_q     <= carry_d;
         idx_q       <= idx_d;
         d_q         <= d_d;
         bout_q      <= bout_d;
         ovf_q       <= ovf_d;
         out_valid_q <= out_valid_d;
      end
   end

   // Gating with rst_n keeps in_ready low throughout a reset cycle.
   assign in_ready  = rst_n & (state_q == IDLE);
   assign out_valid = out_valid_q;
   assign d         = d_q;
   assign bout      = bout_q;
   assign ovf       = ovf_q;

endmodule

// File: tb/tb_nibble_sub16.sv
// Randomised self-checking bench for nibble_sub16 against an arithmetic reference model.
module tb_nibble_sub16;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] a;
   logic [15:0] b;
   logic        bin;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] d;
   logic        bout;
   logic        ovf;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   nibble_sub16 #(.WIDTH(16)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .bin       (bin),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .d         (d),
      .bout      (bout),
      .ovf       (ovf)
   );

   function automatic void model(input logic [15:0] ma, input logic [15:0] mb, input logic mbin,
                                 output logic [15:0] md, output logic mbout, output logic movf);
      int          ua, ub, sa, sb, sd, raw;
      logic [31:0] raw_bits;
      ua       = int'({16'h0000, ma});
      ub       = int'({16'h0000, mb});
      raw      = ua - ub - int'({31'd0, mbin});
      raw_bits = raw;
      mbout    = (ua < ub + int'({31'd0, mbin}));
      sa       = int'($signed(ma));
      sb       = int'($signed(mb));
      sd       = sa - sb - int'({31'd0, mbin});
      movf     = (sd > 32767) || (sd < -32768);
`ifdef NIBBLE_SUB_SAT_EN
      md       = mbout ? 16'h0000 : raw_bits[15:0];
`else
      md       = raw_bits[15:0];
`endif
   endfunction

   task automatic do_txn(input logic [15:0] ta, input logic [15:0] tb_v, input logic tbin,
                         input int hold, input bit junk);
      logic [15:0] ed;
      logic        eb, eo;
      int          waited, lat;
      model(ta, tb_v, tbin, ed, eb, eo);
      waited = 0;
      while (in_ready !== 1'b1 && waited < 20) begin
         @(posedge clk); #1; waited++;
      end
      n_tests++;
      if (in_ready !== 1'b1) begin
         n_fail++; $display("FAIL in_ready_wait: got %b, want 1", in_ready);
      end
      a = ta; b = tb_v; bin = tbin; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = junk;
      a = 16'($urandom); b = 16'($urandom); bin = 1'($urandom);
      n_tests++;
      if (in_ready !== 1'b0) begin
         n_fail++; $display("FAIL accept_ready: got %b, want 0", in_ready);
      end
      lat = 0;
      while (out_valid !== 1'b1 && lat < 20) begin
         @(posedge clk); #1; lat++;
      end
      n_tests++;
      if (lat !== 4) begin
         n_fail++; $display("FAIL latency: got %0d edges, want 4", lat);
      end
      n_tests++;
      if ({d, bout, ovf} !== {ed, eb, eo}) begin
         n_fail++;
         $display("FAIL result a=%h b=%h bin=%b: got d=%h bout=%b ovf=%b, want d=%h bout=%b ovf=%b",
                  ta, tb_v, tbin, d, bout, ovf, ed, eb, eo);
      end
      for (int i = 0; i < hold; i++) begin
         if (junk) begin
            in_valid = 1'b1; a = 16'($urandom); b = 16'($urandom); bin = 1'($urandom);
         end
         @(posedge clk); #1;
         n_tests++;
         if ({out_valid, in_ready, d, bout, ovf} !== {1'b1, 1'b0, ed, eb, eo}) begin
            n_fail++;
            $display("FAIL hold%0d: got v=%b rdy=%b d=%h bout=%b ovf=%b, want v=1 rdy=0 d=%h bout=%b ovf=%b",
                     i, out_valid, in_ready, d, bout, ovf, ed, eb, eo);
         end
      end
      in_valid = 1'b0; out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      n_tests++;
      if ({out_valid, in_ready} !== 2'b01) begin
         n_fail++; $display("FAIL deliver: got v=%b rdy=%b, want v=0 rdy=1", out_valid, in_ready);
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; a = 16'h0000; b = 16'h0000; bin = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      n_tests++;
      if ({in_ready, out_valid, d, bout, ovf} !== 20'h00000) begin
         n_fail++; $display("FAIL reset_state: got rdy=%b v=%b d=%h bout=%b ovf=%b, want all 0",
                            in_ready, out_valid, d, bout, ovf);
      end
      rst_n = 1'b1; #1;
      n_tests++;
      if ({in_ready, out_valid} !== 2'b10) begin
         n_fail++; $display("FAIL reset_release: got rdy=%b v=%b, want rdy=1 v=0", in_ready, out_valid);
      end
   endtask

   task automatic test_directed();
      do_txn(16'h24D7, 16'h03F8, 1'b0, 0, 1'b0);
      do_txn(16'h0000, 16'h0001, 1'b0, 0, 1'b0);
      do_txn(16'h8000, 16'h0001, 1'b0, 0, 1'b0);
      do_txn(16'h0005, 16'h0003, 1'b1, 0, 1'b0);
      do_txn(16'h1234, 16'h1234, 1'b0, 0, 1'b0);
      do_txn(16'hFFFF, 16'hFFFF, 1'b1, 0, 1'b0);
      do_txn(16'h7FFF, 16'hFFFF, 1'b0, 0, 1'b0);
      do_txn(16'h8000, 16'h0000, 1'b1, 1, 1'b0);
   endtask

   task automatic test_backpressure();
      do_txn(16'h5A5A, 16'h1234, 1'b1, 3, 1'b1);
      do_txn(16'h0100, 16'h0200, 1'b0, 3, 1'b1);
   endtask

   task automatic test_reset_mid_run();
      a = 16'hABCD; b = 16'h1357; bin = 1'b1; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b0;
      @(posedge clk); #1;
      n_tests++;
      if ({in_ready, out_valid, d, bout, ovf} !== 20'h00000) begin
         n_fail++; $display("FAIL mid_run_reset: got rdy=%b v=%b d=%h bout=%b ovf=%b, want all 0",
                            in_ready, out_valid, d, bout, ovf);
      end
      rst_n = 1'b1; #1;
      n_tests++;
      if ({in_ready, out_valid} !== 2'b10) begin
         n_fail++; $display("FAIL mid_run_release: got rdy=%b v=%b, want rdy=1 v=0", in_ready, out_valid);
      end
      do_txn(16'h4000, 16'h3FFF, 1'b0, 0, 1'b0);
   endtask

   task automatic test_random();
      for (int i = 0; i < 40; i++) begin
         do_txn(16'($urandom), 16'($urandom), 1'($urandom), int'($urandom_range(0, 2)), 1'($urandom));
      end
   endtask

   task automatic test_back_to_back();
      for (int i = 0; i < 8; i++) begin
         do_txn(16'($urandom), 16'($urandom), 1'($urandom), 0, 1'b0);
      end
   endtask

   initial begin
      test_reset();
      test_directed();
      test_backpressure();
      test_reset_mid_run();
      test_random();
      test_back_to_back();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
